mem_fifo_ctrl: RTL and testbench

- Single-port FIFO controller sitting directly upstream of, and consuming the output of, the 128x5 synchronous memory (sync_mem).
- Turns a valid/ready push stream into sync_mem write cycles and drains it with sync_mem read cycles.
- Presents the oldest entry on a registered valid/ready pop interface.
- Owns all pointers, occupancy and arbitration; sync_mem is pure storage.

---
 rtl/mem_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_mem_fifo_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a 128x5 single-port sync_mem; registered valid/ready pop side.
// Optional MEM_FIFO_CTRL_FLUSH_EN adds a synchronous flush input that clears everything except out_data.
module mem_fifo_ctrl #(
  parameter int DW = 5,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset,
`ifdef MEM_FIFO_CTRL_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_HOLD} rd_state_t;

  rd_state_t     r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  logic w_flush;
  logic w_rd_issue;
  logic w_in_ready;
  logic w_wr;
  logic w_pop;

`ifdef MEM_FIFO_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A read wins the single memory port; pushes stall for that cycle.
  assign w_rd_issue = !reset && !w_flush && (r_level != '0) &&
                      ((r_state == RD_IDLE) || ((r_state == RD_HOLD) && out_ready));
  assign w_in_ready = !reset && !w_flush && (r_level != DEPTH) && !w_rd_issue;
  assign w_wr       = in_valid && w_in_ready;
  assign w_pop      = r_out_valid && out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_level;
  assign mem_wr    = w_wr;
  assign mem_rd    = w_rd_issue;
  assign mem_addr  = reset ? '0 : (w_rd_issue ? r_rd_ptr : r_wr_ptr);
  assign mem_din   = reset ? '0 : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RD_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_flush) begin
      // out_data deliberately survives a flush
      r_state     <= RD_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr)       r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd_issue})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      case (r_state)
        RD_IDLE: if (w_rd_issue) r_state <= RD_WAIT;
        RD_WAIT: begin
          r_out_data  <= mem_dout;
          r_out_valid <= 1'b1;
          r_state     <= RD_HOLD;
        end
        RD_HOLD: if (w_pop) begin
          r_out_valid <= 1'b0;
          r_state     <= w_rd_issue ? RD_WAIT : RD_IDLE;
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a behavioural sync_mem; covers flush when MEM_FIFO_CTRL_FLUSH_EN is set.
module tb_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, in_ready, out_valid;
  logic [4:0] in_data, out_data, mem_din, mem_dout;
  logic [7:0] level;
  logic       mem_wr, mem_rd;
  logic [6:0] mem_addr;
`ifdef MEM_FIFO_CTRL_FLUSH_EN
  logic       flush;
`endif
  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_fifo_ctrl #(.DW(5), .AW(7)) dut (
    .clk(clk), .reset(reset),
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [4:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_addr];
  end

  // inputs change at negedge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    in_valid = 1'b1; in_data = 5'h1F; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready c=%0d got=%b exp=0", c, in_ready); end
      nchk++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin nfail++; $display("FAIL rst_mem_ctl c=%0d got wr=%b rd=%b exp 0/0", c, mem_wr, mem_rd); end
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid c=%0d got=%b exp=0", c, out_valid); end
      nchk++; if (level !== 8'd0) begin nfail++; $display("FAIL rst_level c=%0d got=%0d exp=0", c, level); end
      nchk++; if (mem_addr !== 7'd0 || mem_din !== 5'd0) begin nfail++; $display("FAIL rst_mem_bus c=%0d got addr=%0d din=%0h exp 0/0", c, mem_addr, mem_din); end
      tick();
    end
    #1;
    nchk++; if (out_data !== 5'd0) begin nfail++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_data = 5'b00011;
    #1;
    nchk++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 7'd0 || mem_din !== 5'd3) begin nfail++; $display("FAIL single_write got wr=%b rd=%b addr=%0d din=%0h exp 1/0/0/03", mem_wr, mem_rd, mem_addr, mem_din); end
    tick(); in_valid = 1'b0;
    #1;
    nchk++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 7'd0) begin nfail++; $display("FAIL single_read got rd=%b wr=%b addr=%0d exp 1/0/0", mem_rd, mem_wr, mem_addr); end
    nchk++; if (level !== 8'd1) begin nfail++; $display("FAIL single_level1 got=%0d exp=1", level); end
    tick(); #1;
    nchk++; if (out_valid !== 1'b0 || level !== 8'd0) begin nfail++; $display("FAIL single_wait got valid=%b level=%0d exp 0/0", out_valid, level); end
    tick(); #1;
    nchk++; if (out_valid !== 1'b1 || out_data !== 5'b00011) begin nfail++; $display("FAIL single_capture got valid=%b data=%0h exp 1/03", out_valid, out_data); end
    nchk++; if (level !== 8'd0) begin nfail++; $display("FAIL single_level0 got=%0d exp=0", level); end
    tick(); #1;
    nchk++; if (out_valid !== 1'b1 || out_data !== 5'b00011) begin nfail++; $display("FAIL single_hold got valid=%b data=%0h exp 1/03", out_valid, out_data); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL single_popped got=%b exp=0", out_valid); end
  endtask

  task automatic test_conflict();
    do_reset();
    in_valid = 1'b1; in_data = 5'h0A;
    tick();
    in_data = 5'h0B; #1;
    nchk++; if (in_ready !== 1'b0 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 7'd0) begin nfail++; $display("FAIL conflict_stall got rdy=%b rd=%b wr=%b addr=%0d exp 0/1/0/0", in_ready, mem_rd, mem_wr, mem_addr); end
    tick(); #1;
    nchk++; if (in_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 7'd1 || mem_din !== 5'h0B) begin nfail++; $display("FAIL conflict_retry got rdy=%b wr=%b addr=%0d din=%0h exp 1/1/1/0b", in_ready, mem_wr, mem_addr, mem_din); end
    tick(); in_valid = 1'b0; #1;
    nchk++; if (out_valid !== 1'b1 || out_data !== 5'h0A || level !== 8'd1) begin nfail++; $display("FAIL conflict_first got valid=%b data=%0h level=%0d exp 1/0a/1", out_valid, out_data, level); end
    out_ready = 1'b1; #1;
    nchk++; if (mem_rd !== 1'b1 || mem_addr !== 7'd1) begin nfail++; $display("FAIL conflict_popread got rd=%b addr=%0d exp 1/1", mem_rd, mem_addr); end
    tick(); out_ready = 1'b0; tick(); #1;
    nchk++; if (out_valid !== 1'b1 || out_data !== 5'h0B) begin nfail++; $display("FAIL conflict_second got valid=%b data=%0h exp 1/0b", out_valid, out_data); end
  endtask

  task automatic test_fill_full();
    int d = 0;
    int got = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_data = 5'(d); #1;
      if (in_ready) d++;
      tick();
    end
    #1;
    nchk++; if (d != 129) begin nfail++; $display("FAIL full_accepted got=%0d exp=129", d); end
    nchk++; if (level !== 8'd128 || in_ready !== 1'b0 || mem_wr !== 1'b0) begin nfail++; $display("FAIL full_state got level=%0d rdy=%b wr=%b exp 128/0/0", level, in_ready, mem_wr); end
    nchk++; if (out_valid !== 1'b1 || out_data !== 5'd0) begin nfail++; $display("FAIL full_head got valid=%b data=%0h exp 1/00", out_valid, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 600 && got < 129; c++) begin
      #1;
      if (out_valid) begin
        nchk++; if (out_data !== 5'(got)) begin nfail++; $display("FAIL drain_order idx=%0d got=%0h exp=%0h", got, out_data, 5'(got)); end
        got++;
      end
      tick();
    end
    out_ready = 1'b0; #1;
    nchk++; if (got != 129 || level !== 8'd0) begin nfail++; $display("FAIL drain_count got pops=%0d level=%0d exp 129/0", got, level); end
  endtask

  task automatic test_wrap();
    logic [4:0] q[$];
    logic [4:0] e;
    int pushed = 0;
    int popped = 0;
    int maxlvl = 0;
    do_reset();
    for (int c = 0; c < 6000 && popped < 300; c++) begin
      in_valid  = (pushed < 300) && ($urandom_range(0, 3) != 0);
      in_data   = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (in_valid && in_ready) begin q.push_back(in_data); pushed++; end
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 5'bx;
        nchk++; if (out_data !== e) begin nfail++; $display("FAIL wrap_order idx=%0d got=%0h exp=%0h", popped, out_data, e); end
        popped++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    nchk++; if (popped != 300 || q.size() != 0) begin nfail++; $display("FAIL wrap_count got pops=%0d left=%0d exp 300/0", popped, q.size()); end
    nchk++; if (maxlvl > 128) begin nfail++; $display("FAIL wrap_maxlevel got=%0d exp<=128", maxlvl); end
  endtask

  // leaves the DUT in RD_WAIT with level=10 and out_data=10 (entries 10..21 pushed)
  task automatic setup_wait();
    int d = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 40 && d < 12; c++) begin
      in_data = 5'(10 + d); #1;
      if (in_ready) d++;
      tick();
    end
    in_valid = 1'b0; tick(); tick(); #1;
    nchk++; if (level !== 8'd11 || out_valid !== 1'b1 || out_data !== 5'd10) begin nfail++; $display("FAIL setup_hold got level=%0d valid=%b data=%0h exp 11/1/0a", level, out_valid, out_data); end
    out_ready = 1'b1; #1;
    nchk++; if (mem_rd !== 1'b1) begin nfail++; $display("FAIL setup_read got=%b exp=1", mem_rd); end
    tick(); out_ready = 1'b0; #1;
    nchk++; if (level !== 8'd10 || out_valid !== 1'b0) begin nfail++; $display("FAIL setup_wait got level=%0d valid=%b exp 10/0", level, out_valid); end
  endtask

  task automatic test_mid_reset();
    setup_wait();
    reset = 1'b1;
    tick(); #1;
    nchk++; if (level !== 8'd0 || out_valid !== 1'b0 || out_data !== 5'd0) begin nfail++; $display("FAIL midrst_state got level=%0d valid=%b data=%0h exp 0/0/00", level, out_valid, out_data); end
    reset = 1'b0;
    tick(); #1;
    nchk++; if (out_valid !== 1'b0 || out_data !== 5'd0 || level !== 8'd0 || mem_rd !== 1'b0) begin nfail++; $display("FAIL midrst_nocapture got valid=%b data=%0h level=%0d rd=%b exp 0/00/0/0", out_valid, out_data, level, mem_rd); end
  endtask

`ifdef MEM_FIFO_CTRL_FLUSH_EN
  task automatic test_flush();
    setup_wait();
    flush = 1'b1; in_valid = 1'b1; in_data = 5'h15; #1;
    nchk++; if (in_ready !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin nfail++; $display("FAIL flush_block got rdy=%b wr=%b rd=%b exp 0/0/0", in_ready, mem_wr, mem_rd); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    nchk++; if (level !== 8'd0 || out_valid !== 1'b0 || out_data !== 5'd10) begin nfail++; $display("FAIL flush_state got level=%0d valid=%b data=%0h exp 0/0/0a", level, out_valid, out_data); end
    tick(); #1;
    nchk++; if (out_valid !== 1'b0 || out_data !== 5'd10) begin nfail++; $display("FAIL flush_nocapture got valid=%b data=%0h exp 0/0a", out_valid, out_data); end
  endtask
`endif

  initial begin
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_conflict();
    test_fill_full();
    test_wrap();
    test_mid_reset();
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
